// File: rtl/silife_gen_ctrl.sv
// silife_gen_ctrl: Wishbone control/status block that paces SiLife grid generations.
// Produces masked per-grid generation pulses from a period timer, single-step
// requests or a bounded N-generation run, and keeps a running generation count.
module silife_gen_ctrl #(
  parameter int                      GRIDS          = 4,
  parameter int                      PERIOD_WIDTH   = 24,
  parameter int                      CNT_WIDTH      = 32,
  parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = '0,
  parameter logic [11:0]             BLOCK_SEL      = 12'h000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [31:0]      i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [GRIDS-1:0] o_gen,
  output logic             o_wrap,
  output logic             o_max7219_enable,
  output logic             o_irq
);

  localparam logic [11:0] OFS_CTRL   = 12'h000;
  localparam logic [11:0] OFS_PERIOD = 12'h004;
  localparam logic [11:0] OFS_STEPS  = 12'h008;
  localparam logic [11:0] OFS_GEN    = 12'h00C;
  localparam logic [11:0] OFS_STATUS = 12'h010;

  logic                    run;
  logic                    step_pend;
  logic                    irq_en;
  logic                    done;
  logic [GRIDS-1:0]        grid_mask;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0]    steps;
  logic [CNT_WIDTH-1:0]    generation;

  logic        wb_req;
  logic        wr_en;
  logic [11:0] offset;
  logic [31:0] rd_data;
  logic        timer_tick;
  logic        tick;
  logic        final_tick;
  logic        unused_addr;

  // The ack term blocks a held strobe from being taken twice.
  assign wb_req = i_wb_cyc & i_wb_stb & (i_wb_addr[23:12] == BLOCK_SEL) & ~o_wb_ack;
  assign wr_en  = wb_req & i_wb_we;
  assign offset = i_wb_addr[11:0];
  assign unused_addr = ^i_wb_addr[31:24];

  // Step ticks never touch STEPS; only timer ticks count down a bounded run.
  assign timer_tick = run & (cnt >= period);
  assign tick       = timer_tick | step_pend;
  assign final_tick = timer_tick & (steps == CNT_WIDTH'(1));

  // Read mux; unmapped offsets and the step bit read as zero.
  always_comb begin
    rd_data = '0;
    case (offset)
      OFS_CTRL: begin
        rd_data[0]          = run;
        rd_data[2]          = o_max7219_enable;
        rd_data[3]          = o_wrap;
        rd_data[4]          = irq_en;
        rd_data[8 +: GRIDS] = grid_mask;
      end
      OFS_PERIOD: rd_data[PERIOD_WIDTH-1:0] = period;
      OFS_STEPS:  rd_data[CNT_WIDTH-1:0]    = steps;
      OFS_GEN:    rd_data[CNT_WIDTH-1:0]    = generation;
      OFS_STATUS: begin
        rd_data[0] = run;
        rd_data[1] = done;
      end
      default: rd_data = '0;
    endcase
  end

  // Wishbone acknowledge and registered read data, one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= wb_req;
      if (wb_req) o_wb_data <= rd_data;
    end
  end

  // CTRL register; a CTRL write overrides the run clear from the final bounded tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      run              <= 1'b0;
      step_pend        <= 1'b0;
      o_max7219_enable <= 1'b0;
      o_wrap           <= 1'b0;
      irq_en           <= 1'b0;
      grid_mask        <= '1;
    end else begin
      step_pend <= 1'b0;
      if (final_tick) run <= 1'b0;
      if (wr_en && offset == OFS_CTRL) begin
        run              <= i_wb_data[0];
        o_max7219_enable <= i_wb_data[2];
        o_wrap           <= i_wb_data[3];
        irq_en           <= i_wb_data[4];
        grid_mask        <= i_wb_data[8 +: GRIDS];
        if (i_wb_data[1] && !run) step_pend <= 1'b1;
      end
    end
  end

  // PERIOD register.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= DEFAULT_PERIOD;
    end else if (wr_en && offset == OFS_PERIOD) begin
      period <= i_wb_data[PERIOD_WIDTH-1:0];
    end
  end

  // Period timer: held at zero while stopped, wraps to zero on each tick.
  always_ff @(posedge clk) begin
    if (reset || !run || timer_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // STEPS countdown; a bus write takes priority over the decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      steps <= '0;
    end else if (wr_en && offset == OFS_STEPS) begin
      steps <= i_wb_data[CNT_WIDTH-1:0];
    end else if (timer_tick && steps != '0) begin
      steps <= steps - 1'b1;
    end
  end

  // Generation counter; a bus write in the same cycle as a tick drops that increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      generation <= '0;
    end else if (wr_en && offset == OFS_GEN) begin
      generation <= i_wb_data[CNT_WIDTH-1:0];
    end else if (tick) begin
      generation <= generation + 1'b1;
    end
  end

  // Sticky done flag; setting beats a simultaneous write-1 clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (final_tick) begin
      done <= 1'b1;
    end else if (wr_en && offset == OFS_STATUS && i_wb_data[1]) begin
      done <= 1'b0;
    end
  end

  // Registered generation pulses and interrupt level.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_gen <= '0;
      o_irq <= 1'b0;
    end else begin
      o_gen <= tick ? grid_mask : '0;
      o_irq <= done & irq_en;
    end
  end

endmodule

// File: tb/tb_silife_gen_ctrl.sv
// tb_silife_gen_ctrl: self-checking bench for the SiLife generation controller.
module tb_silife_gen_ctrl;

  localparam int GRIDS = 4;
  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_PERIOD = 32'h0000_0004;
  localparam logic [31:0] A_STEPS  = 32'h0000_0008;
  localparam logic [31:0] A_GEN    = 32'h0000_000C;
  localparam logic [31:0] A_STATUS = 32'h0000_0010;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_cyc, wb_stb, wb_we;
  logic [31:0]      wb_addr, wb_wdata;
  logic             wb_ack;
  logic [31:0]      wb_rdata;
  logic [GRIDS-1:0] gen;
  logic             wrap, max_en, irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  silife_gen_ctrl #(
    .GRIDS(GRIDS), .PERIOD_WIDTH(24), .CNT_WIDTH(32),
    .DEFAULT_PERIOD(24'd0), .BLOCK_SEL(12'h000)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
    .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
    .o_gen(gen), .o_wrap(wrap), .o_max7219_enable(max_en), .o_irq(irq)
  );

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl_word(input logic [3:0] mask, input bit irq_e,
                                            input bit wr, input bit mx, input bit st, input bit rn);
    return (32'(mask) << 8) | (32'(irq_e) << 4) | (32'(wr) << 3) | (32'(mx) << 2)
           | (32'(st) << 1) | 32'(rn);
  endfunction

  // Bus transfer; returns one cycle after the request edge when acked.
  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit expect_ack, output logic [31:0] rdata);
    bit got;
    if (wb_ack) tick_clk();
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick_clk();
      if (wb_ack) got = 1;
    end
    rdata = wb_rdata;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    n_checks++;
    if (got != expect_ack) begin
      n_fail++;
      $display("FAIL wb_ack addr=%h we=%0d: ack seen %0d, required %0d", addr, we, got, expect_ack);
    end
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, addr, data, 1'b1, dummy);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
    wb_xfer(1'b0, addr, 32'h0, 1'b1, data);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_regs [5] = '{32'h0000_0F00, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
    repeat (3) tick_clk();
    n_checks++;
    if ({wb_ack, wb_rdata, gen, wrap, max_en, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b data=%h gen=%b wrap=%b max=%b irq=%b, required all 0",
               wb_ack, wb_rdata, gen, wrap, max_en, irq);
    end
    reset = 0;
    tick_clk();
    for (int i = 0; i < 5; i++) begin
      wb_read(32'(i * 4), rd);
      n_checks++;
      if (rd !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL reset_reg ofs=%h: got %h required %h", i * 4, rd, exp_regs[i]);
      end
    end
    wb_read(32'h14, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h required 0", rd);
    end
  endtask

  task automatic test_free_run(input int p);
    logic [31:0] rd;
    logic [3:0]  mask;
    logic [3:0]  exp;
    bit w, m;
    int n_gen;
    mask = 4'($urandom_range(1, 15));
    w = 1'($urandom_range(0, 1));
    m = 1'($urandom_range(0, 1));
    n_gen = 5;
    wb_write(A_GEN, 32'h0);
    wb_write(A_PERIOD, 32'(p));
    wb_write(A_CTRL, ctrl_word(mask, 0, w, m, 0, 1));
    n_checks++;
    if (wrap !== w || max_en !== m) begin
      n_fail++;
      $display("FAIL free_run_cfg: wrap=%b max=%b required %b %b", wrap, max_en, w, m);
    end
    for (int k = 1; k <= n_gen * (p + 1); k++) begin
      tick_clk();
      exp = (k % (p + 1) == 0) ? mask : 4'h0;
      n_checks++;
      if (gen !== exp) begin
        n_fail++;
        $display("FAIL free_run_gen p=%0d k=%0d: got %b required %b", p, k, gen, exp);
      end
    end
    // The stop write lands one edge later; with period 0 that edge also ticks.
    wb_write(A_CTRL, ctrl_word(mask, 0, w, m, 0, 0));
    if (p == 0) n_gen++;
    exp = (p == 0) ? mask : 4'h0;
    for (int k = 0; k < 2 * (p + 1) + 2; k++) begin
      n_checks++;
      if (gen !== exp) begin
        n_fail++;
        $display("FAIL free_run_stop p=%0d k=%0d: got %b required %b", p, k, gen, exp);
      end
      exp = 4'h0;
      tick_clk();
    end
    wb_read(A_GEN, rd);
    n_checks++;
    if (rd !== 32'(n_gen)) begin
      n_fail++;
      $display("FAIL free_run_count p=%0d: got %0d required %0d", p, rd, n_gen);
    end
  endtask

  task automatic test_steps(input int n, input int p);
    logic [31:0] rd;
    logic [3:0]  mask;
    logic [3:0]  exp;
    logic        exp_irq;
    int kf;
    mask = 4'($urandom_range(1, 15));
    kf = n * (p + 1);
    wb_write(A_GEN, 32'h0);
    wb_write(A_PERIOD, 32'(p));
    wb_write(A_STEPS, 32'(n));
    wb_write(A_CTRL, ctrl_word(mask, 1, 0, 0, 0, 1));
    for (int k = 1; k <= kf + 4; k++) begin
      tick_clk();
      exp = (k % (p + 1) == 0 && k <= kf) ? mask : 4'h0;
      exp_irq = (k >= kf + 1);
      n_checks++;
      if (gen !== exp || irq !== exp_irq) begin
        n_fail++;
        $display("FAIL steps_run n=%0d p=%0d k=%0d: gen=%b irq=%b required %b %b",
                 n, p, k, gen, irq, exp, exp_irq);
      end
    end
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h2) begin n_fail++; $display("FAIL steps_status: got %h required 2", rd); end
    wb_read(A_STEPS, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL steps_left: got %0d required 0", rd); end
    wb_read(A_GEN, rd);
    n_checks++;
    if (rd !== 32'(n)) begin n_fail++; $display("FAIL steps_count: got %0d required %0d", rd, n); end
    wb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== ctrl_word(mask, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL steps_ctrl: got %h required %h", rd, ctrl_word(mask, 1, 0, 0, 0, 0));
    end
    wb_write(A_STATUS, 32'h2);
    tick_clk();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b required 0", irq); end
    wb_write(A_STATUS, 32'h1);
    wb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL status_after_clear: got %h required 0", rd); end
    wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 0, 0));
  endtask

  task automatic test_single_step(input logic [3:0] mask);
    logic [31:0] rd;
    wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 0, 0));
    wb_write(A_GEN, 32'h0);
    for (int i = 0; i < 3; i++) begin
      wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 1, 0));
      n_checks++;
      if (gen !== 4'h0) begin n_fail++; $display("FAIL step_early i=%0d: got %b required 0", i, gen); end
      tick_clk();
      n_checks++;
      if (gen !== mask) begin n_fail++; $display("FAIL step_pulse i=%0d: got %b required %b", i, gen, mask); end
      tick_clk();
      n_checks++;
      if (gen !== 4'h0) begin n_fail++; $display("FAIL step_width i=%0d: got %b required 0", i, gen); end
    end
    wb_read(A_GEN, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL step_count mask=%b: got %0d required 3", mask, rd); end
    wb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== ctrl_word(mask, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL step_readback: got %h required %h", rd, ctrl_word(mask, 0, 0, 0, 0, 0));
    end
    wb_write(A_PERIOD, 32'd1000);
    wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 0, 1));
    wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 1, 1));
    for (int k = 0; k < 5; k++) begin
      tick_clk();
      n_checks++;
      if (gen !== 4'h0) begin n_fail++; $display("FAIL step_while_run k=%0d: got %b required 0", k, gen); end
    end
    wb_write(A_CTRL, ctrl_word(mask, 0, 0, 0, 0, 0));
    wb_read(A_GEN, rd);
    n_checks++;
    if (rd !== 32'd3) begin n_fail++; $display("FAIL step_while_run_count: got %0d required 3", rd); end
  endtask

  task automatic test_period_lower();
    logic [3:0] exp;
    wb_write(A_GEN, 32'h0);
    wb_write(A_PERIOD, 32'd10);
    wb_write(A_CTRL, ctrl_word(4'hF, 0, 0, 0, 0, 1));
    repeat (5) tick_clk();
    wb_write(A_PERIOD, 32'd2);
    for (int j = 0; j <= 7; j++) begin
      exp = (j >= 1 && (j - 1) % 3 == 0) ? 4'hF : 4'h0;
      n_checks++;
      if (gen !== exp) begin n_fail++; $display("FAIL period_lower j=%0d: got %b required %b", j, gen, exp); end
      tick_clk();
    end
    wb_write(A_CTRL, ctrl_word(4'hF, 0, 0, 0, 0, 0));
  endtask

  task automatic test_wrap_unselected();
    logic [31:0] rd;
    wb_write(A_GEN, 32'hFFFF_FFFF);
    wb_write(A_CTRL, ctrl_word(4'hF, 0, 0, 0, 1, 0));
    wb_read(A_GEN, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL gen_wrap: got %h required 0", rd); end
    wb_write(A_PERIOD, 32'd7);
    wb_xfer(1'b1, 32'h0000_1004, 32'd99, 1'b0, rd);
    wb_xfer(1'b1, 32'h0000_1000, 32'h0000_0F1F, 1'b0, rd);
    wb_xfer(1'b0, 32'h0000_100C, 32'h0, 1'b0, rd);
    for (int k = 0; k < 4; k++) begin
      tick_clk();
      n_checks++;
      if (gen !== 4'h0 || wrap !== 1'b0 || max_en !== 1'b0) begin
        n_fail++;
        $display("FAIL unsel_side_effect k=%0d: gen=%b wrap=%b max=%b required 0", k, gen, wrap, max_en);
      end
    end
    wb_read(A_PERIOD, rd);
    n_checks++;
    if (rd !== 32'd7) begin n_fail++; $display("FAIL unsel_period: got %0d required 7", rd); end
    wb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0000_0F00) begin n_fail++; $display("FAIL unsel_ctrl: got %h required 00000f00", rd); end
    wb_write(32'h0000_0020, 32'hDEAD_BEEF);
    wb_read(32'h0000_0020, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_write: got %h required 0", rd); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    logic [31:0] exp_regs [5] = '{32'h0000_0F00, 32'h0, 32'h0, 32'h0, 32'h0};
    wb_write(A_STEPS, 32'd7);
    wb_write(A_PERIOD, 32'd10);
    wb_write(A_CTRL, ctrl_word(4'hA, 1, 1, 1, 0, 1));
    repeat ($urandom_range(3, 15)) tick_clk();
    reset = 1;
    tick_clk();
    n_checks++;
    if ({wb_ack, wb_rdata, gen, wrap, max_en, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ack=%b data=%h gen=%b wrap=%b max=%b irq=%b, required all 0",
               wb_ack, wb_rdata, gen, wrap, max_en, irq);
    end
    reset = 0;
    for (int k = 0; k < 25; k++) begin
      tick_clk();
      n_checks++;
      if (gen !== 4'h0) begin n_fail++; $display("FAIL reset_mid_gen k=%0d: got %b required 0", k, gen); end
    end
    for (int i = 0; i < 5; i++) begin
      wb_read(32'(i * 4), rd);
      n_checks++;
      if (rd !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL reset_mid_reg ofs=%h: got %h required %h", i * 4, rd, exp_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run(3);
    repeat (3) test_free_run($urandom_range(0, 6));
    test_steps(3, 0);
    repeat (3) test_steps($urandom_range(1, 5), $urandom_range(0, 3));
    test_single_step(4'b0101);
    test_single_step(4'b0000);
    test_single_step(4'($urandom_range(0, 15)));
    test_period_lower();
    test_wrap_unselected();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
